// File: rtl/chord_arpeggiator_if.sv
// Control and tone-datapath signals between the Ear Training sequencer and the
// chord arpeggiator that shares one freq_pwm instance across up to three notes.
interface chord_arpeggiator_if;
    // Handshake: start is a one-cycle request that is honoured only while busy=0;
    // busy rises the cycle after an accepted start and stays high until done pulses
    // for one cycle (or until abort/reset drops it without a done pulse).
    logic        start;
    logic        abort;
    logic [1:0]  note_num;
    logic [6:0]  note_id_0;
    logic [6:0]  note_id_1;
    logic [6:0]  note_id_2;
    logic [31:0] clks_per_period;
    logic        new_period;
    logic        tone_en;
    logic [1:0]  cur_note;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    modport master (
        output start, abort, note_num, note_id_0, note_id_1, note_id_2,
        input  clks_per_period, new_period, tone_en, cur_note, busy, done, state_dbg
    );

    modport slave (
        input  start, abort, note_num, note_id_0, note_id_1, note_id_2,
        output clks_per_period, new_period, tone_en, cur_note, busy, done, state_dbg
    );
endinterface

// File: rtl/chord_arpeggiator.sv
// Plays up to three latched chord notes one after another through a single
// freq_pwm, decoding each note ID to a period with a one-octave-per-cycle divider.
module chord_arpeggiator #(
    parameter int unsigned NOTE_CLKS = 50000000,
    parameter int unsigned GAP_CLKS  = 10000000
) (
    input  logic               clk,
    input  logic               reset,
    chord_arpeggiator_if.slave arp
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DECODE = 3'd2,
        PLAY   = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CLKS - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CLKS == 0) ? 32'd0 : 32'(GAP_CLKS - 1);
    localparam logic        HAS_GAP   = (GAP_CLKS != 0);

    state_t      state;
    logic [1:0]  note_num_q;
    logic [1:0]  cur_note_q;
    logic [6:0]  id0_q;
    logic [6:0]  id1_q;
    logic [6:0]  id2_q;
    logic [6:0]  rem_q;
    logic [2:0]  oct_q;
    logic [31:0] cnt_q;
    logic [31:0] period_q;
    logic        new_period_q;
    logic        tone_en_q;
    logic        busy_q;
    logic        done_q;

    logic [6:0]  cur_id;
    logic [6:0]  next_id;
    logic [1:0]  next_note;
    logic [1:0]  last_note;
    logic        cur_valid;
    logic [31:0] period;

    function automatic logic [6:0] pick_id(input logic [1:0] idx, input logic [6:0] a,
                                           input logic [6:0] b, input logic [6:0] c);
        case (idx)
            2'd0:    pick_id = a;
            2'd1:    pick_id = b;
            default: pick_id = c;
        endcase
    endfunction

    // Octave-0 periods (id 4..15) for C..B; higher octaves halve by right shift.
    function automatic logic [31:0] base_period(input logic [3:0] semi);
        case (semi)
            4'd0:    base_period = 32'd3057805;
            4'd1:    base_period = 32'd2886184;
            4'd2:    base_period = 32'd2724194;
            4'd3:    base_period = 32'd2571298;
            4'd4:    base_period = 32'd2426982;
            4'd5:    base_period = 32'd2290765;
            4'd6:    base_period = 32'd2162195;
            4'd7:    base_period = 32'd2040840;
            4'd8:    base_period = 32'd1926296;
            4'd9:    base_period = 32'd1818182;
            4'd10:   base_period = 32'd1716135;
            4'd11:   base_period = 32'd1619816;
            default: base_period = 32'd0;
        endcase
    endfunction

    assign next_note = cur_note_q + 2'd1;
    assign last_note = note_num_q - 2'd1;
    assign cur_id    = pick_id(cur_note_q, id0_q, id1_q, id2_q);
    assign next_id   = pick_id(next_note, id0_q, id1_q, id2_q);
    assign cur_valid = (cur_id >= 7'd4) && (cur_id <= 7'd99);
    assign period    = base_period(rem_q[3:0]) >> oct_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            note_num_q   <= 2'd0;
            cur_note_q   <= 2'd0;
            id0_q        <= 7'd0;
            id1_q        <= 7'd0;
            id2_q        <= 7'd0;
            rem_q        <= 7'd0;
            oct_q        <= 3'd0;
            cnt_q        <= 32'd0;
            period_q     <= 32'd0;
            new_period_q <= 1'b0;
            tone_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            new_period_q <= 1'b0;
            done_q       <= 1'b0;
            if (state != IDLE && arp.abort) begin
                state     <= IDLE;
                tone_en_q <= 1'b0;
                busy_q    <= 1'b0;
                cnt_q     <= 32'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arp.start) begin
                            state      <= LOAD;
                            busy_q     <= 1'b1;
                            cur_note_q <= 2'd0;
                            cnt_q      <= 32'd0;
                        end
                    end
                    LOAD: begin
                        note_num_q <= arp.note_num;
                        id0_q      <= arp.note_id_0;
                        id1_q      <= arp.note_id_1;
                        id2_q      <= arp.note_id_2;
                        cur_note_q <= 2'd0;
                        cnt_q      <= 32'd0;
                        rem_q      <= arp.note_id_0 - 7'd4;
                        oct_q      <= 3'd0;
                        if (arp.note_num == 2'd0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DECODE;
                        end
                    end
                    DECODE: begin
                        // Invalid IDs skip the divider and play as a silent rest.
                        if (cur_valid && rem_q >= 7'd12) begin
                            rem_q <= rem_q - 7'd12;
                            oct_q <= oct_q + 3'd1;
                        end else begin
                            state <= PLAY;
                            cnt_q <= 32'd0;
                            if (cur_valid) begin
                                period_q     <= period;
                                new_period_q <= 1'b1;
                                tone_en_q    <= 1'b1;
                            end
                        end
                    end
                    PLAY: begin
                        if (cnt_q == NOTE_LAST) begin
                            tone_en_q <= 1'b0;
                            cnt_q     <= 32'd0;
                            if (cur_note_q == last_note) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end else if (HAS_GAP) begin
                                state <= GAP;
                            end else begin
                                state      <= DECODE;
                                cur_note_q <= next_note;
                                rem_q      <= next_id - 7'd4;
                                oct_q      <= 3'd0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            state      <= DECODE;
                            cnt_q      <= 32'd0;
                            cur_note_q <= next_note;
                            rem_q      <= next_id - 7'd4;
                            oct_q      <= 3'd0;
                        end else begin
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        cnt_q <= 32'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign arp.clks_per_period = period_q;
    assign arp.new_period      = new_period_q;
    assign arp.tone_en         = tone_en_q;
    assign arp.cur_note        = cur_note_q;
    assign arp.busy            = busy_q;
    assign arp.done            = done_q;
    assign arp.state_dbg       = state;
endmodule

// File: tb/tb_chord_arpeggiator.sv
// Directed bench for chord_arpeggiator with NOTE_CLKS=8, GAP_CLKS=4; cycle 1 is the
// LOAD cycle that follows the clock edge sampling start.
module tb_chord_arpeggiator;
    logic clk;
    logic reset;

    chord_arpeggiator_if arp ();

    chord_arpeggiator #(
        .NOTE_CLKS(8),
        .GAP_CLKS (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .arp  (arp.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // scoreboard: one entry per expected new_period pulse
    logic [31:0] exp_q[$];
    logic [31:0] exp_cyc_q[$];
    logic [31:0] exp_note_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_note(input int cyc, input int idx, input logic [31:0] per);
        exp_cyc_q.push_back(32'(cyc));
        exp_note_q.push_back(32'(idx));
        exp_q.push_back(per);
    endtask

    task automatic check_idle_outputs(input string name, input logic [31:0] exp_clks);
        check_val({name, ".clks"},   arp.clks_per_period, exp_clks);
        check_val({name, ".np"},     32'(arp.new_period), 32'd0);
        check_val({name, ".tone"},   32'(arp.tone_en), 32'd0);
        check_val({name, ".busy"},   32'(arp.busy), 32'd0);
        check_val({name, ".done"},   32'(arp.done), 32'd0);
        check_val({name, ".state"},  32'(arp.state_dbg), 32'd0);
    endtask

    // Driver + monitor: pulse start, then observe ncyc cycles. exp_done=0 means no
    // done pulse is expected. abort_at/reset_at/disturb_at < 0 disable that event;
    // abort_at == 0 raises abort together with start.
    task automatic run_seq(input string name, input logic [1:0] num,
                           input logic [6:0] i0, input logic [6:0] i1, input logic [6:0] i2,
                           input int exp_done, input int exp_tone, input int exp_win,
                           input int abort_at, input int reset_at, input int disturb_at,
                           input int ncyc);
        int   n_np;
        int   np_exp;
        int   n_done;
        int   done_cyc;
        int   n_tone;
        int   n_win;
        logic prev_tone;
        n_np = 0; n_done = 0; done_cyc = 0; n_tone = 0; n_win = 0; prev_tone = 1'b0;
        np_exp = exp_q.size();

        @(posedge clk); #1;
        arp.note_num  = num;
        arp.note_id_0 = i0;
        arp.note_id_1 = i1;
        arp.note_id_2 = i2;
        arp.start     = 1'b1;
        arp.abort     = (abort_at == 0);
        @(posedge clk); #1;
        arp.start = 1'b0;
        arp.abort = 1'b0;

        for (int c = 1; c <= ncyc; c++) begin
            if (c == 1) check_val({name, ".load_busy"}, 32'(arp.busy), 32'd1);
            if (arp.new_period) begin
                n_np++;
                if (exp_q.size() > 0) begin
                    check_val({name, ".np_cycle"},  32'(c), exp_cyc_q.pop_front());
                    check_val({name, ".np_note"},   32'(arp.cur_note), exp_note_q.pop_front());
                    check_val({name, ".np_period"}, arp.clks_per_period, exp_q.pop_front());
                end
            end
            if (arp.tone_en) n_tone++;
            if (arp.tone_en && !prev_tone) n_win++;
            prev_tone = arp.tone_en;
            if (arp.done) begin
                n_done++;
                done_cyc = c;
                check_val({name, ".done_busy"}, 32'(arp.busy), 32'd0);
            end
            if (abort_at > 0 && c == abort_at + 1) begin
                check_val({name, ".abort_tone"},  32'(arp.tone_en), 32'd0);
                check_val({name, ".abort_busy"},  32'(arp.busy), 32'd0);
                check_val({name, ".abort_state"}, 32'(arp.state_dbg), 32'd0);
            end
            if (reset_at >= 0 && c == reset_at + 1) begin
                check_idle_outputs({name, ".rst"}, 32'd0);
                check_val({name, ".rst_note"}, 32'(arp.cur_note), 32'd0);
            end

            arp.start = 1'b0;
            arp.abort = 1'b0;
            reset     = 1'b0;
            if (c == abort_at) arp.abort = 1'b1;
            if (c == reset_at) reset = 1'b1;
            if (c == disturb_at) begin
                arp.start     = 1'b1;
                arp.note_num  = 2'd1;
                arp.note_id_0 = 7'd100;
                arp.note_id_1 = 7'd4;
                arp.note_id_2 = 7'd4;
            end
            @(posedge clk); #1;
        end

        check_val({name, ".np_count"},   32'(n_np), 32'(np_exp));
        check_val({name, ".tone_count"}, 32'(n_tone), 32'(exp_tone));
        check_val({name, ".tone_wins"},  32'(n_win), 32'(exp_win));
        if (exp_done == 0) begin
            check_val({name, ".done_count"}, 32'(n_done), 32'd0);
        end else begin
            check_val({name, ".done_count"}, 32'(n_done), 32'd1);
            check_val({name, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
        end
        exp_q.delete();
        exp_cyc_q.delete();
        exp_note_q.delete();
    endtask

    initial begin
        reset         = 1'b1;
        arp.start     = 1'b0;
        arp.abort     = 1'b0;
        arp.note_num  = 2'd0;
        arp.note_id_0 = 7'd0;
        arp.note_id_1 = 7'd0;
        arp.note_id_2 = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset", 32'd0);
        check_val("reset.note", 32'(arp.cur_note), 32'd0);
        reset = 1'b0;

        // single note id 28: C, octave 2
        expect_note(5, 0, 32'd764451);
        run_seq("one", 2'd1, 7'd28, 7'd0, 7'd0, 13, 8, 1, -1, -1, -1, 16);

        // three notes with gaps; start and input changes mid-PLAY must be ignored
        expect_note(5, 0, 32'd764451);
        expect_note(20, 1, 32'd454545);
        expect_note(36, 2, 32'd382225);
        run_seq("chord", 2'd3, 7'd28, 7'd37, 7'd40, 44, 24, 3, -1, -1, 8, 47);

        // invalid first id is an 8-cycle rest
        expect_note(19, 1, 32'd382225);
        run_seq("rest", 2'd2, 7'd2, 7'd40, 7'd0, 27, 8, 1, -1, -1, -1, 30);

        // zero notes: done two cycles after start
        run_seq("empty", 2'd0, 7'd28, 7'd28, 7'd28, 2, 0, 0, -1, -1, -1, 6);

        // abort in 3rd PLAY cycle of note 1
        expect_note(5, 0, 32'd764451);
        expect_note(20, 1, 32'd454545);
        run_seq("abort", 2'd3, 7'd28, 7'd37, 7'd40, 0, 11, 2, 22, -1, -1, 30);

        // reset mid-GAP, then a fresh full sequence
        expect_note(5, 0, 32'd764451);
        run_seq("rstgap", 2'd3, 7'd28, 7'd37, 7'd40, 0, 8, 1, -1, 14, -1, 20);
        expect_note(5, 0, 32'd764451);
        expect_note(20, 1, 32'd454545);
        expect_note(36, 2, 32'd382225);
        run_seq("fresh", 2'd3, 7'd28, 7'd37, 7'd40, 44, 24, 3, -1, -1, -1, 47);

        // lowest valid id with abort alongside start: start wins
        expect_note(3, 0, 32'd3057805);
        run_seq("id4", 2'd1, 7'd4, 7'd0, 7'd0, 11, 8, 1, 0, -1, -1, 14);

        // highest valid id: B, octave 7
        expect_note(10, 0, 32'd12654);
        run_seq("id99", 2'd1, 7'd99, 7'd0, 7'd0, 18, 8, 1, -1, -1, -1, 21);

        // first invalid id above range: rest, period keeps last value
        run_seq("id100", 2'd1, 7'd100, 7'd0, 7'd0, 11, 0, 0, -1, -1, -1, 14);
        check_val("id100.hold_clks", arp.clks_per_period, 32'd12654);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
